// File: rtl/match_controller.sv
// match_controller: match-level sequencer; tracks scores, gates the round engine reset, paces rounds
module match_controller #(
    parameter int WIN_SCORE    = 5,
    parameter int PAUSE_CYCLES = 130_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mouse_left_local_i,
    input  logic       mouse_left_remote_i,
    input  logic       winner_valid_i,
    input  logic [1:0] winner_code_i,
    output logic       game_rst_o,
    output logic [2:0] state_o,
    output logic [3:0] score1_o,
    output logic [3:0] score2_o,
    output logic [1:0] last_code_o,
    output logic [1:0] match_winner_o
);
    localparam int CW = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
    localparam logic [3:0] WIN = 4'(WIN_SCORE);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        READY      = 3'd1,
        PLAYING    = 3'd2,
        ROUND_OVER = 3'd3,
        MATCH_OVER = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    score1_q, score1_d, score2_q, score2_d, inc1, inc2;
    logic [1:0]    last_code_q, last_code_d, match_winner_q, match_winner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rdy_l_q, rdy_l_d, rdy_r_q, rdy_r_d;
    logic          prev_l_q, prev_r_q, arm_q, game_rst_q;
    logic          rise_l, rise_r;

    // arm_q masks the first cycle after reset so a button held through reset is not an edge
    assign rise_l = arm_q & mouse_left_local_i & ~prev_l_q;
    assign rise_r = arm_q & mouse_left_remote_i & ~prev_r_q;
    assign inc1   = score1_q + 4'd1;
    assign inc2   = score2_q + 4'd1;

    // next-state, score and pause-counter logic
    always_comb begin
        state_d        = state_q;
        score1_d       = score1_q;
        score2_d       = score2_q;
        last_code_d    = last_code_q;
        match_winner_d = match_winner_q;
        cnt_d          = cnt_q;
        rdy_l_d        = rdy_l_q;
        rdy_r_d        = rdy_r_q;
        unique case (state_q)
            IDLE: begin
                rdy_l_d = rdy_l_q | rise_l;
                rdy_r_d = rdy_r_q | rise_r;
                if (rdy_l_d && rdy_r_d) begin
                    state_d     = READY;
                    rdy_l_d     = 1'b0;
                    rdy_r_d     = 1'b0;
                    score1_d    = 4'd0;
                    score2_d    = 4'd0;
                    last_code_d = 2'b00;
                end
            end
            READY: state_d = PLAYING;
            PLAYING: begin
                if (winner_valid_i && winner_code_i != 2'b00) begin
                    last_code_d = winner_code_i;
                    if (winner_code_i == 2'b01) score1_d = inc1;
                    if (winner_code_i == 2'b10) score2_d = inc2;
                    if (winner_code_i == 2'b01 && inc1 == WIN) begin
                        state_d        = MATCH_OVER;
                        match_winner_d = 2'b01;
                    end else if (winner_code_i == 2'b10 && inc2 == WIN) begin
                        state_d        = MATCH_OVER;
                        match_winner_d = 2'b10;
                    end else begin
                        state_d = ROUND_OVER;
                        cnt_d   = CW'(PAUSE_CYCLES - 1);
                    end
                end
            end
            ROUND_OVER: begin
                if (cnt_q == '0) state_d = PLAYING;
                else cnt_d = cnt_q - CW'(1);
            end
            MATCH_OVER: begin
                if (rise_l || rise_r) begin
                    state_d        = IDLE;
                    match_winner_d = 2'b00;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state, score and button-history registers; game_rst is registered from the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            score1_q       <= 4'd0;
            score2_q       <= 4'd0;
            last_code_q    <= 2'b00;
            match_winner_q <= 2'b00;
            cnt_q          <= '0;
            rdy_l_q        <= 1'b0;
            rdy_r_q        <= 1'b0;
            prev_l_q       <= 1'b0;
            prev_r_q       <= 1'b0;
            arm_q          <= 1'b0;
            game_rst_q     <= 1'b1;
        end else begin
            state_q        <= state_d;
            score1_q       <= score1_d;
            score2_q       <= score2_d;
            last_code_q    <= last_code_d;
            match_winner_q <= match_winner_d;
            cnt_q          <= cnt_d;
            rdy_l_q        <= rdy_l_d;
            rdy_r_q        <= rdy_r_d;
            prev_l_q       <= mouse_left_local_i;
            prev_r_q       <= mouse_left_remote_i;
            arm_q          <= 1'b1;
            game_rst_q     <= (state_d != PLAYING);
        end
    end

    assign game_rst_o     = game_rst_q;
    assign state_o        = state_q;
    assign score1_o       = score1_q;
    assign score2_o       = score2_q;
    assign last_code_o    = last_code_q;
    assign match_winner_o = match_winner_q;
endmodule

// File: tb/tb_match_controller.sv
// tb_match_controller: table-driven directed check of the match sequencer (WIN_SCORE=3, PAUSE_CYCLES=10)
module tb_match_controller;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       loc = 1'b0, rem = 1'b0, wv = 1'b0;
    logic [1:0] wc = 2'b00;
    logic       game_rst;
    logic [2:0] state;
    logic [3:0] score1, score2;
    logic [1:0] last_code, match_winner;
    int         passed = 0, total = 0;

    typedef struct {
        logic       r, l, m, v;
        logic [1:0] c;
        int         n;
        logic [2:0] st;
        logic       g;
        logic [3:0] s1, s2;
        logic [1:0] lc, mw;
    } vec_t;
    vec_t tv[$];

    match_controller #(.WIN_SCORE(3), .PAUSE_CYCLES(10)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .mouse_left_local_i  (loc),
        .mouse_left_remote_i (rem),
        .winner_valid_i      (wv),
        .winner_code_i       (wc),
        .game_rst_o          (game_rst),
        .state_o             (state),
        .score1_o            (score1),
        .score2_o            (score2),
        .last_code_o         (last_code),
        .match_winner_o      (match_winner)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, l, m, v, input logic [1:0] c, input int n,
                       input logic [2:0] st, input logic g, input logic [3:0] s1, s2,
                       input logic [1:0] lc, mw);
        vec_t t;
        t.r = r; t.l = l; t.m = m; t.v = v; t.c = c; t.n = n;
        t.st = st; t.g = g; t.s1 = s1; t.s2 = s2; t.lc = lc; t.mw = mw;
        tv.push_back(t);
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got st/gr/s1/s2/lc/mw=%h required %h", name, got, exp);
    endtask

    initial begin
        int cnt;
        //   rst loc rem wv code  n    st  gr s1 s2 lc     mw
        add(0, 0, 0, 0, 2'b00, 2,  0, 1, 0, 0, 2'b00, 2'b00); // reset state
        add(1, 0, 0, 0, 2'b00, 2,  0, 1, 0, 0, 2'b00, 2'b00);
        add(1, 1, 0, 0, 2'b00, 1,  0, 1, 0, 0, 2'b00, 2'b00); // local press
        add(1, 0, 0, 0, 2'b00, 20, 0, 1, 0, 0, 2'b00, 2'b00);
        add(1, 0, 1, 0, 2'b00, 1,  1, 1, 0, 0, 2'b00, 2'b00); // remote press -> READY
        add(1, 0, 1, 0, 2'b00, 1,  2, 0, 0, 0, 2'b00, 2'b00); // PLAYING, game_rst low
        add(1, 1, 1, 0, 2'b00, 3,  2, 0, 0, 0, 2'b00, 2'b00); // buttons ignored in PLAYING
        add(1, 0, 0, 1, 2'b01, 1,  3, 1, 1, 0, 2'b01, 2'b00); // P1 point
        add(1, 0, 0, 1, 2'b10, 1,  3, 1, 1, 0, 2'b01, 2'b00); // strobe ignored in ROUND_OVER
        add(1, 0, 0, 0, 2'b00, 8,  3, 1, 1, 0, 2'b01, 2'b00); // 10th pause cycle
        add(1, 0, 0, 0, 2'b00, 1,  2, 0, 1, 0, 2'b01, 2'b00);
        add(1, 0, 0, 1, 2'b11, 1,  3, 1, 1, 0, 2'b11, 2'b00); // draw
        add(1, 0, 0, 0, 2'b00, 9,  3, 1, 1, 0, 2'b11, 2'b00);
        add(1, 0, 0, 0, 2'b00, 1,  2, 0, 1, 0, 2'b11, 2'b00);
        add(1, 0, 0, 1, 2'b00, 1,  2, 0, 1, 0, 2'b11, 2'b00); // code 00 ignored
        add(1, 0, 0, 1, 2'b10, 1,  3, 1, 1, 1, 2'b10, 2'b00);
        add(1, 0, 0, 0, 2'b00, 10, 2, 0, 1, 1, 2'b10, 2'b00);
        add(1, 0, 0, 1, 2'b10, 1,  3, 1, 1, 2, 2'b10, 2'b00);
        add(1, 0, 0, 0, 2'b00, 10, 2, 0, 1, 2, 2'b10, 2'b00);
        add(1, 0, 0, 1, 2'b10, 1,  4, 1, 1, 3, 2'b10, 2'b10); // P2 wins match
        add(1, 0, 0, 1, 2'b01, 3,  4, 1, 1, 3, 2'b10, 2'b10); // strobe ignored in MATCH_OVER
        add(1, 1, 0, 0, 2'b00, 1,  0, 1, 1, 3, 2'b10, 2'b00); // click -> IDLE, scores held
        add(1, 0, 0, 0, 2'b00, 1,  0, 1, 1, 3, 2'b10, 2'b00);
        add(1, 0, 0, 1, 2'b10, 1,  0, 1, 1, 3, 2'b10, 2'b00); // strobe ignored in IDLE
        add(1, 1, 1, 0, 2'b00, 1,  1, 1, 0, 0, 2'b00, 2'b00); // simultaneous ready, READY clears
        add(1, 0, 0, 0, 2'b00, 1,  2, 0, 0, 0, 2'b00, 2'b00);
        add(1, 0, 0, 1, 2'b01, 1,  3, 1, 1, 0, 2'b01, 2'b00);
        add(1, 0, 0, 0, 2'b00, 10, 2, 0, 1, 0, 2'b01, 2'b00);
        add(1, 0, 0, 1, 2'b01, 1,  3, 1, 2, 0, 2'b01, 2'b00);
        add(1, 1, 0, 0, 2'b00, 4,  3, 1, 2, 0, 2'b01, 2'b00); // mid-pause, button held
        add(0, 1, 0, 0, 2'b00, 1,  0, 1, 0, 0, 2'b00, 2'b00); // reset mid-pause
        add(1, 1, 0, 0, 2'b00, 3,  0, 1, 0, 0, 2'b00, 2'b00); // held button: no edge
        add(1, 1, 1, 0, 2'b00, 2,  0, 1, 0, 0, 2'b00, 2'b00); // only remote flag set
        add(1, 0, 1, 0, 2'b00, 1,  0, 1, 0, 0, 2'b00, 2'b00);
        add(1, 1, 1, 0, 2'b00, 1,  1, 1, 0, 0, 2'b00, 2'b00); // fresh local edge -> READY
        add(1, 0, 0, 0, 2'b00, 1,  2, 0, 0, 0, 2'b00, 2'b00);

        for (int i = 0; i < tv.size(); i++) begin
            rst_n = tv[i].r; loc = tv[i].l; rem = tv[i].m; wv = tv[i].v; wc = tv[i].c;
            repeat (tv[i].n) @(posedge clk);
            #1;
            check($sformatf("vec%0d", i),
                  {1'b0, state, game_rst, score1, score2, last_code, match_winner},
                  {1'b0, tv[i].st, tv[i].g, tv[i].s1, tv[i].s2, tv[i].lc, tv[i].mw});
        end

        // exact pause length: count ROUND_OVER cycles with game_rst high
        wv = 1'b1; wc = 2'b01;
        @(posedge clk); #1;
        wv = 1'b0; wc = 2'b00;
        cnt = 0;
        while (state == 3'd3 && game_rst && cnt < 50) begin
            cnt++;
            @(posedge clk); #1;
        end
        check("pause_len", 16'(cnt), 16'd10);
        check("after_pause", {1'b0, state, game_rst, score1, score2, last_code, match_winner},
              {1'b0, 3'd2, 1'b0, 4'd1, 4'd0, 2'b01, 2'b00});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
